// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control for load-use, taken branches and multi-cycle ALU ops.
// Define HAZARD_PERF_EN to add saturating stall_cnt/flush_cnt performance counters.
module hazard_ctrl #(
   parameter int MD_LAT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ID_EX_MemRead,
   input  logic [4:0] ID_EX_rd,
   input  logic [4:0] IF_ID_rs1,
   input  logic [4:0] IF_ID_rs2,
   input  logic       ID_EX_md,
   input  logic       branch_taken,
   output logic       PC_write,
   output logic       IF_ID_write,
   output logic       IF_ID_flush,
   output logic       ID_EX_flush,
   output logic       EX_hold,
   output logic       md_done
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);
   typedef enum logic [1:0] {IDLE, MD_RUN, MD_DONE} state_t;
   state_t     state, state_nx;
   logic [3:0] cnt, cnt_nx;
   logic       load_use;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE:    if (ID_EX_md) begin
                     state_nx = MD_RUN;
                     cnt_nx   = 4'(MD_LAT - 2);
                  end
         MD_RUN:  if (cnt == 4'd0) state_nx = MD_DONE;
                  else cnt_nx = cnt - 4'd1;
         default: state_nx = IDLE;
      endcase
   end
   // The triggering IDLE cycle counts as the first of the MD_LAT held cycles.
   assign EX_hold     = (state == IDLE && ID_EX_md) || state == MD_RUN;
   assign md_done     = state == MD_DONE;
   assign load_use    = ID_EX_MemRead && ID_EX_rd != 5'd0 &&
                        (ID_EX_rd == IF_ID_rs1 || ID_EX_rd == IF_ID_rs2);
   assign PC_write    = !EX_hold && (branch_taken || !load_use);
   assign IF_ID_write = PC_write;
   assign IF_ID_flush = !EX_hold && branch_taken;
   assign ID_EX_flush = !EX_hold && (branch_taken || load_use);
`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!PC_write && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
         if (IF_ID_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif
endmodule
